// File: rtl/sipo_pkg.sv
// Shared types and defaults for the serial-in/parallel-out word receiver.
package sipo_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    // Shift direction encodings, matching the lsb_first input level.
    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    localparam int DEFAULT_WIDTH       = 4;
    localparam int DEFAULT_GAP_TIMEOUT = 16;

endpackage

// File: rtl/sipo_word_receiver_shift_core.sv
// Shift register with bidirectional insert and an output register that
// captures the (optionally complemented) finished word.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load_first,
    input  logic             i_shift,
    input  logic             i_dir,
    input  logic             i_inv,
    input  logic             i_capture,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_ins;

    // Insert the new bit into either an empty register (first bit) or the
    // running partial word, on the side selected by the direction.
    always_comb begin
        w_base = i_load_first ? '0 : r_sh;
        if (i_dir == DIR_LSB_FIRST) begin
            w_ins = {i_bit, w_base[WIDTH-1:1]};
        end else begin
            w_ins = {w_base[WIDTH-2:0], i_bit};
        end
    end

    // Shift register and output word; the output is taken from the insert
    // result so the last bit is included in the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sh   <= '0;
            o_data <= '0;
        end else begin
            if (i_load_first || i_shift) begin
                r_sh <= w_ins;
            end
            if (i_capture) begin
                o_data <= i_inv ? ~w_ins : w_ins;
            end
        end
    end

endmodule

// File: rtl/sipo_word_receiver.sv
// Frames WIDTH serial bits into a word; aborts on restart or idle timeout.
module sipo_word_receiver
    import sipo_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int GAP_TIMEOUT = DEFAULT_GAP_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             frame_start,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             lsb_first,
    input  logic             invert_en,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             frame_err
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int GAP_W = $clog2(GAP_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(GAP_TIMEOUT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [GAP_W-1:0] r_gap;
    logic [GAP_W-1:0] w_gap_nxt;
    logic             r_lsb;
    logic             r_inv;
    logic             w_load_first;
    logic             w_shift;
    logic             w_capture;
    logic             w_abort;
    logic             w_dir;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and datapath strobes. A frame_start inside RECV takes
    // priority over completion: the bit always opens a new frame.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_gap_nxt    = r_gap;
        w_load_first = 1'b0;
        w_shift      = 1'b0;
        w_capture    = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bit_valid && frame_start) begin
                    w_load_first = 1'b1;
                    w_cnt_nxt    = CNT_W'(1);
                    w_gap_nxt    = '0;
                    w_state_nxt  = RECV;
                end
            end
            RECV: begin
                if (bit_valid && frame_start) begin
                    w_load_first = 1'b1;
                    w_abort      = 1'b1;
                    w_cnt_nxt    = CNT_W'(1);
                    w_gap_nxt    = '0;
                end else if (bit_valid) begin
                    w_shift   = 1'b1;
                    w_gap_nxt = '0;
                    if (r_cnt == CNT_LAST) begin
                        w_capture   = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end else begin
                    w_gap_nxt = r_gap + 1'b1;
                    if (w_gap_nxt == GAP_LIMIT) begin
                        w_abort     = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Counters, latched frame config and the one-cycle status pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_gap      <= '0;
            r_lsb      <= DIR_MSB_FIRST;
            r_inv      <= 1'b0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_gap      <= w_gap_nxt;
            data_valid <= w_capture;
            frame_err  <= w_abort;
            if (w_load_first) begin
                r_lsb <= lsb_first;
                r_inv <= invert_en;
            end
        end
    end

    // The first bit of a frame must use the live direction input, since the
    // latched copy only updates on that same edge.
    assign w_dir = w_load_first ? lsb_first : r_lsb;
    assign busy  = (r_state == RECV);

    sipo_shift_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_load_first(w_load_first),
        .i_shift     (w_shift),
        .i_dir       (w_dir),
        .i_inv       (r_inv),
        .i_capture   (w_capture),
        .i_bit       (serial_in),
        .o_data      (data_out)
    );

endmodule

// File: tb/tb_sipo_word_receiver.sv
// Self-checking bench for sipo_word_receiver (WIDTH=4, GAP_TIMEOUT=16).
module tb_sipo_word_receiver;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       serial_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       lsb_first = 1'b0;
    logic       invert_en = 1'b0;
    logic [3:0] data_out;
    logic       data_valid;
    logic       busy;
    logic       frame_err;

    int n_checks = 0;
    int n_errors = 0;
    int n_dv     = 0;
    int n_ferr   = 0;
    int n_pushed = 0;
    logic [3:0] sb_q[$];

    typedef struct {
        logic [3:0] seq;   // seq[3] is sent first
        logic       lsb;
        logic       inv;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[6];

    sipo_word_receiver #(
        .WIDTH(4),
        .GAP_TIMEOUT(16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_start(frame_start),
        .serial_in  (serial_in),
        .bit_valid  (bit_valid),
        .lsb_first  (lsb_first),
        .invert_en  (invert_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: each data_valid pops the next expected word.
    always @(negedge clk) begin
        if (reset_n) begin
            if (frame_err) n_ferr++;
            if (data_valid) begin
                n_dv++;
                chk("dv_without_err", {31'b0, frame_err}, 32'd0);
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_dv", 32'd1, 32'd0);
                end else begin
                    chk("sb_word", {28'b0, data_out}, {28'b0, sb_q.pop_front()});
                end
            end
        end
    end

    // One clock of stimulus; returns 1 time unit after the sampling edge.
    task automatic drive(input logic fs, input logic bv, input logic b);
        frame_start = fs;
        bit_valid   = bv;
        serial_in   = b;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        bit_valid   = 1'b0;
        serial_in   = 1'b0;
    endtask

    task automatic expect_word(input logic [3:0] w);
        sb_q.push_back(w);
        n_pushed++;
    endtask

    // Full back-to-back frame; optionally flips the config inputs mid-frame.
    task automatic send_frame(input vec_t v, input bit flip);
        lsb_first = v.lsb;
        invert_en = v.inv;
        drive(1'b1, 1'b1, v.seq[3]);
        chk("busy_after_first", {31'b0, busy}, 32'd1);
        if (flip) begin
            lsb_first = ~v.lsb;
            invert_en = ~v.inv;
        end
        drive(1'b0, 1'b1, v.seq[2]);
        drive(1'b0, 1'b1, v.seq[1]);
        chk("busy_before_last", {31'b0, busy}, 32'd1);
        expect_word(v.exp);
        drive(1'b0, 1'b1, v.seq[0]);
        chk("dv_latency", {31'b0, data_valid}, 32'd1);
        chk("word", {28'b0, data_out}, {28'b0, v.exp});
        chk("busy_after_done", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dv0;
        int fe0;

        vecs[0] = '{seq: 4'b1011, lsb: 1'b0, inv: 1'b0, exp: 4'b1011};
        vecs[1] = '{seq: 4'b1011, lsb: 1'b1, inv: 1'b1, exp: 4'b0010};
        vecs[2] = '{seq: 4'b0001, lsb: 1'b0, inv: 1'b0, exp: 4'b0001};
        vecs[3] = '{seq: 4'b1100, lsb: 1'b1, inv: 1'b0, exp: 4'b0011};
        vecs[4] = '{seq: 4'b0111, lsb: 1'b0, inv: 1'b1, exp: 4'b1000};
        vecs[5] = '{seq: 4'b1000, lsb: 1'b1, inv: 1'b1, exp: 4'b1110};

        // Reset state
        #22;
        chk("rst_data_out", {28'b0, data_out}, 32'd0);
        chk("rst_flags", {29'b0, data_valid, busy, frame_err}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Bits in IDLE without frame_start are ignored
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        chk("idle_ignore_busy", {31'b0, busy}, 32'd0);

        // Table vectors, each followed by a cycle to confirm a single pulse
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i], (i % 2) == 1);
            drive(1'b0, 1'b0, 1'b0);
            chk("dv_single", {31'b0, data_valid}, 32'd0);
            chk("word_hold", {28'b0, data_out}, {28'b0, vecs[i].exp});
        end
        chk("no_err_table", n_ferr, 32'd0);

        // Gaps of 3 idle cycles between bits: 0,1,1,0 MSB-first
        lsb_first = 1'b0;
        invert_en = 1'b0;
        drive(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            repeat (3) drive(1'b0, 1'b0, 1'b0);
            if (k == 2) expect_word(4'b0110);
            drive(1'b0, 1'b1, (k == 2) ? 1'b0 : 1'b1);
        end
        chk("gap_dv", {31'b0, data_valid}, 32'd1);
        chk("gap_word", {28'b0, data_out}, 32'b0110);
        drive(1'b0, 1'b0, 1'b0);
        chk("gap_no_err", n_ferr, 32'd0);

        // Timeout: 2 bits then idle; 15 idle cycles is still within the limit
        dv0 = n_dv;
        fe0 = n_ferr;
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        repeat (15) drive(1'b0, 1'b0, 1'b0);
        chk("to_not_yet_err", {31'b0, frame_err}, 32'd0);
        chk("to_not_yet_busy", {31'b0, busy}, 32'd1);
        drive(1'b0, 1'b0, 1'b0);
        chk("to_err_pulse", {31'b0, frame_err}, 32'd1);
        chk("to_busy_drop", {31'b0, busy}, 32'd0);
        chk("to_data_hold", {28'b0, data_out}, 32'b0110);
        drive(1'b0, 1'b0, 1'b0);
        chk("to_err_single", {31'b0, frame_err}, 32'd0);
        chk("to_err_count", n_ferr - fe0, 32'd1);
        chk("to_no_dv", n_dv - dv0, 32'd0);

        // Restart: 2 bits, then frame_start with 1,1,1,1
        fe0 = n_ferr;
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        chk("rs_err_pulse", {31'b0, frame_err}, 32'd1);
        chk("rs_busy", {31'b0, busy}, 32'd1);
        drive(1'b0, 1'b1, 1'b1);
        chk("rs_err_single", {31'b0, frame_err}, 32'd0);
        drive(1'b0, 1'b1, 1'b1);
        chk("rs_no_early_dv", {31'b0, data_valid}, 32'd0);
        expect_word(4'b1111);
        drive(1'b0, 1'b1, 1'b1);
        chk("rs_dv", {31'b0, data_valid}, 32'd1);
        chk("rs_word", {28'b0, data_out}, 32'hF);
        drive(1'b0, 1'b0, 1'b0);
        chk("rs_err_count", n_ferr - fe0, 32'd1);

        // Reset mid-frame after 3 bits
        fe0 = n_ferr;
        dv0 = n_dv;
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_data", {28'b0, data_out}, 32'd0);
        chk("mid_rst_flags", {29'b0, data_valid, busy, frame_err}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0);
        chk("mid_rst_no_pulses", (n_ferr - fe0) + (n_dv - dv0), 32'd0);

        // Back-to-back frames: 0,0,0,1 then 1,0,1,0 with no idle cycle
        dv0 = n_dv;
        lsb_first = 1'b0;
        invert_en = 1'b0;
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        expect_word(4'b0001);
        drive(1'b0, 1'b1, 1'b1);
        chk("b2b_word1", {28'b0, data_out}, 32'b0001);
        drive(1'b1, 1'b1, 1'b1);
        chk("b2b_busy2", {31'b0, busy}, 32'd1);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        expect_word(4'b1010);
        drive(1'b0, 1'b1, 1'b0);
        chk("b2b_word2", {28'b0, data_out}, 32'b1010);
        drive(1'b0, 1'b0, 1'b0);
        chk("b2b_dv_count", n_dv - dv0, 32'd2);

        // Scoreboard drained
        drive(1'b0, 1'b0, 1'b0);
        chk("sb_empty", sb_q.size(), 32'd0);
        chk("sb_dv_total", n_dv, n_pushed);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
